// File: rtl/wb_exception_pkg.sv
// wb_exception_pkg: shared CP0 numbers, excodes, exception vector and WB record type.
package wb_exception_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] EX_ENTRY_DEF = 32'hBFC0_0380;
  localparam logic [4:0] CP0_EPC = 5'd14;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP = 5'd9;
  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;
  typedef enum logic {RUN, FLUSH} flush_state_e;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      ex_code;
    logic            bd;
    logic [31:0]     badvaddr;
    logic            eret;
    logic            mtc0;
    logic            mfc0;
    logic [4:0]      cp0_addr;
    logic [31:0]     rt_value;
    logic [4:0]      dest;
    logic [31:0]     result;
  } ws_rec_t;
endpackage

// File: rtl/wb_exception_unit_flush_fsm.sv
// wb_flush_fsm: one-cycle flush sequencer that latches the redirect target on a committed exception or ERET.
module wb_flush_fsm
  import wb_exception_pkg::*;
#(
  parameter logic [PC_W-1:0] EX_ENTRY = EX_ENTRY_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex,
  input  logic            er,
  input  logic [PC_W-1:0] epc,
  output logic            run,
  output logic            ws_flush,
  output logic [PC_W-1:0] flush_pc
);
  flush_state_e state_q, state_d;
  logic [PC_W-1:0] flush_pc_q, flush_pc_d;
  always_comb begin
    state_d = (state_q == RUN && (ex || er)) ? FLUSH : RUN;
    flush_pc_d = ex ? EX_ENTRY : er ? epc : flush_pc_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      flush_pc_q <= '0;
    end else begin
      state_q <= state_d;
      flush_pc_q <= flush_pc_d;
    end
  end
  assign run = state_q == RUN;
  assign ws_flush = state_q == FLUSH;
  assign flush_pc = flush_pc_q;
endmodule

// File: rtl/wb_exception_unit.sv
// wb_exception_unit: write-back register and exception commit point driving CP0 and the GPR write port.
module wb_exception_unit
  import wb_exception_pkg::*;
#(
  parameter logic [PC_W-1:0] EX_ENTRY = EX_ENTRY_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ms_to_ws_valid,
  output logic            ws_allowin,
  input  logic [PC_W-1:0] ms_pc,
  input  logic [4:0]      ms_ex_code,
  input  logic            ms_bd,
  input  logic [31:0]     ms_badvaddr,
  input  logic            ms_eret,
  input  logic            ms_mtc0,
  input  logic            ms_mfc0,
  input  logic [4:0]      ms_cp0_addr,
  input  logic [31:0]     ms_rt_value,
  input  logic [4:0]      ms_dest,
  input  logic [31:0]     ms_result,
  output logic [4:0]      cp0_ex_code,
  output logic            cp0_bd,
  output logic            cp0_eret,
  output logic [31:0]     cp0_badvaddr,
  output logic [4:0]      cp0_waddr,
  output logic [31:0]     cp0_wdata,
  output logic [4:0]      cp0_raddr,
  input  logic [31:0]     cp0_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic            ws_flush,
  output logic [PC_W-1:0] flush_pc
);
  ws_rec_t ws_q, ws_d, ms_rec;
  logic ws_valid_q, ws_valid_d;
  logic ex, er, run, mtc0_v, take;
  assign ms_rec = '{pc: ms_pc, ex_code: ms_ex_code, bd: ms_bd, badvaddr: ms_badvaddr,
                    eret: ms_eret, mtc0: ms_mtc0, mfc0: ms_mfc0, cp0_addr: ms_cp0_addr,
                    rt_value: ms_rt_value, dest: ms_dest, result: ms_result};
  assign ex = ws_valid_q & (ws_q.ex_code != '0);
  assign er = ws_valid_q & ws_q.eret & ~ex;
  assign mtc0_v = ws_valid_q & ws_q.mtc0 & ~ex;
  // An ex/er commit and the flush cycle both refuse the offer, which also empties the register.
  always_comb begin
    ws_allowin = run & (~ws_valid_q | ~(ex | er));
    take = ws_allowin & ms_to_ws_valid;
    ws_valid_d = take;
    ws_d = take ? ms_rec : ws_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      ws_q <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      ws_q <= ws_d;
    end
  end
  always_comb begin
    cp0_ex_code = ex ? ws_q.ex_code : '0;
    cp0_bd = ex & ws_q.bd;
    cp0_eret = er;
    cp0_badvaddr = ex ? ws_q.badvaddr : '0;
    cp0_waddr = mtc0_v ? ws_q.cp0_addr : '0;
    cp0_wdata = ex ? ws_q.pc : mtc0_v ? ws_q.rt_value : '0;
    cp0_raddr = er ? CP0_EPC : (ws_valid_q & ws_q.mfc0) ? ws_q.cp0_addr : '0;
    rf_we = ws_valid_q & ~ex & ~er & (ws_q.dest != '0);
    rf_waddr = ws_valid_q ? ws_q.dest : '0;
    rf_wdata = ~ws_valid_q ? '0 : ws_q.mfc0 ? cp0_rdata : ws_q.result;
  end
  wb_flush_fsm #(.EX_ENTRY(EX_ENTRY)) u_fsm (
    .clk(clk),
    .reset(reset),
    .ex(ex),
    .er(er),
    .epc(cp0_rdata),
    .run(run),
    .ws_flush(ws_flush),
    .flush_pc(flush_pc)
  );
endmodule

// File: tb/tb_wb_exception_unit.sv
// tb_wb_exception_unit: directed stimulus with a queued expectation per cycle, checked by an independent monitor.
module tb_wb_exception_unit;
  logic clk = 0, reset = 1;
  logic ms_to_ws_valid, ws_allowin, ms_bd, ms_eret, ms_mtc0, ms_mfc0;
  logic [31:0] ms_pc, ms_badvaddr, ms_rt_value, ms_result;
  logic [4:0] ms_ex_code, ms_cp0_addr, ms_dest;
  logic [4:0] cp0_ex_code, cp0_waddr, cp0_raddr, rf_waddr;
  logic cp0_bd, cp0_eret, rf_we, ws_flush;
  logic [31:0] cp0_badvaddr, cp0_wdata, cp0_rdata, rf_wdata, flush_pc;
  logic [31:0] epc = '0;
  int cyc = 0, n_checks = 0, n_fail = 0;

  typedef struct {
    logic valid; logic [31:0] pc; logic [4:0] exc; logic bd; logic [31:0] bva;
    logic eret, mtc0, mfc0; logic [4:0] addr; logic [31:0] rt; logic [4:0] dest; logic [31:0] res;
  } rec_t;
  typedef struct {
    int cyc; string nm; logic allow, flush; logic [31:0] fpc; logic we; logic [4:0] wa; logic [31:0] wd;
    logic [4:0] exc; logic bd, eret; logic [31:0] bva; logic [4:0] cwa; logic [31:0] cwd; logic [4:0] cra;
  } exp_t;
  exp_t q[$];

  wb_exception_unit dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_ex_code(ms_ex_code), .ms_bd(ms_bd), .ms_badvaddr(ms_badvaddr),
    .ms_eret(ms_eret), .ms_mtc0(ms_mtc0), .ms_mfc0(ms_mfc0), .ms_cp0_addr(ms_cp0_addr),
    .ms_rt_value(ms_rt_value), .ms_dest(ms_dest), .ms_result(ms_result),
    .cp0_ex_code(cp0_ex_code), .cp0_bd(cp0_bd), .cp0_eret(cp0_eret), .cp0_badvaddr(cp0_badvaddr),
    .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ws_flush(ws_flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Minimal CP0: only EPC, written by an exception (bd-adjusted) or by MTC0.
  assign cp0_rdata = (cp0_raddr == 5'd14) ? epc : '0;
  always @(posedge clk)
    if (cp0_ex_code != 0) epc <= cp0_bd ? cp0_wdata - 32'd4 : cp0_wdata;
    else if (cp0_waddr == 5'd14) epc <= cp0_wdata;

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [152:0] act, req;
      e = q.pop_front();
      n_checks++;
      act = {ws_allowin, ws_flush, e.flush ? flush_pc : 32'h0, rf_we, rf_waddr, rf_wdata, cp0_ex_code,
             cp0_bd, cp0_eret, cp0_badvaddr, cp0_waddr, cp0_wdata, cp0_raddr};
      req = {e.allow, e.flush, e.fpc, e.we, e.wa, e.wd, e.exc, e.bd, e.eret, e.bva, e.cwa, e.cwd, e.cra};
      if (e.cyc != cyc || act !== req) begin
        n_fail++;
        $display("FAIL %s cyc=%0d/%0d actual=%h required=%h", e.nm, cyc, e.cyc, act, req);
      end
    end
  end

  function automatic rec_t mk(input logic [31:0] pc, input logic [4:0] exc, input logic bd,
                              input logic [31:0] bva, input logic eret, input logic mtc0, input logic mfc0,
                              input logic [4:0] addr, input logic [31:0] rt, input logic [4:0] dest,
                              input logic [31:0] res);
    return '{1'b1, pc, exc, bd, bva, eret, mtc0, mfc0, addr, rt, dest, res};
  endfunction
  function automatic rec_t idle_r();
    return '{1'b0, 32'h0, 5'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 5'h0, 32'h0};
  endfunction
  function automatic exp_t idle_e(input string nm);
    return '{0, nm, 1'b1, 1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 5'h0, 1'b0, 1'b0, 32'h0, 5'h0, 32'h0, 5'h0};
  endfunction

  task automatic drive(input rec_t r);
    ms_to_ws_valid = r.valid; ms_pc = r.pc; ms_ex_code = r.exc; ms_bd = r.bd; ms_badvaddr = r.bva;
    ms_eret = r.eret; ms_mtc0 = r.mtc0; ms_mfc0 = r.mfc0; ms_cp0_addr = r.addr;
    ms_rt_value = r.rt; ms_dest = r.dest; ms_result = r.res;
  endtask
  task automatic step(input rec_t r, input exp_t e);
    @(posedge clk); #1;
    drive(r);
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    drive(idle_r());
    repeat (2) @(posedge clk);
    #1 e = idle_e("reset_state"); e.cyc = cyc; q.push_back(e);
    @(negedge clk); #1 reset = 0;
    step(idle_r(), idle_e("post_reset"));
    e = idle_e("addu"); e.we = 1; e.wa = 3; e.wd = 32'h55;
    step(mk(32'hBFC00010, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h55), e);
    e = idle_e("syscall_commit"); e.allow = 0; e.exc = 8; e.cwd = 32'hBFC00020;
    step(mk(32'hBFC00020, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0), e);
    e = idle_e("syscall_flush"); e.allow = 0; e.flush = 1; e.fpc = 32'hBFC00380;
    step(mk(32'hBFC00024, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h77), e);
    step(mk(32'hBFC00024, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h77), idle_e("dropped_offer"));
    e = idle_e("mfc0_epc_sys"); e.we = 1; e.wa = 5; e.wd = 32'hBFC00020; e.cra = 14;
    step(mk(32'hBFC00380, 0, 0, 0, 0, 0, 1, 14, 0, 5, 0), e);
    e = idle_e("adel_commit"); e.allow = 0; e.exc = 4; e.bd = 1; e.bva = 32'h1001; e.cwd = 32'hBFC00104;
    step(mk(32'hBFC00104, 4, 1, 32'h1001, 0, 0, 0, 0, 0, 0, 0), e);
    e = idle_e("adel_flush"); e.allow = 0; e.flush = 1; e.fpc = 32'hBFC00380;
    step(idle_r(), e);
    step(idle_r(), idle_e("adel_after"));
    e = idle_e("mfc0_epc_adel"); e.we = 1; e.wa = 6; e.wd = 32'hBFC00100; e.cra = 14;
    step(mk(32'hBFC00380, 0, 0, 0, 0, 0, 1, 14, 0, 6, 0), e);
    e = idle_e("mtc0_epc"); e.cwa = 14; e.cwd = 32'hBFC00200;
    step(mk(32'hBFC00384, 0, 0, 0, 0, 1, 0, 14, 32'hBFC00200, 0, 0), e);
    e = idle_e("eret_commit"); e.allow = 0; e.eret = 1; e.cra = 14;
    step(mk(32'hBFC00388, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), e);
    e = idle_e("eret_flush"); e.allow = 0; e.flush = 1; e.fpc = 32'hBFC00200;
    step(idle_r(), e);
    step(idle_r(), idle_e("eret_after"));
    e = idle_e("eret_ri_commit"); e.allow = 0; e.exc = 10; e.cwd = 32'hBFC00300;
    step(mk(32'hBFC00300, 10, 0, 0, 1, 0, 0, 0, 0, 0, 0), e);
    e = idle_e("eret_ri_flush"); e.allow = 0; e.flush = 1; e.fpc = 32'hBFC00380;
    step(idle_r(), e);
    step(idle_r(), idle_e("eret_ri_after"));
    e = idle_e("ov_mtc0_commit"); e.allow = 0; e.exc = 12; e.cwd = 32'hBFC00400;
    step(mk(32'hBFC00400, 12, 0, 0, 0, 1, 0, 14, 32'hDEADBEEF, 0, 0), e);
    e = idle_e("ov_flush"); e.allow = 0; e.flush = 1; e.fpc = 32'hBFC00380;
    step(idle_r(), e);
    step(idle_r(), idle_e("ov_after"));
    e = idle_e("mfc0_epc_ov"); e.we = 1; e.wa = 2; e.wd = 32'hBFC00400; e.cra = 14;
    step(mk(32'hBFC00380, 0, 0, 0, 0, 0, 1, 14, 0, 2, 0), e);
    e = idle_e("sys2_commit"); e.allow = 0; e.exc = 8; e.cwd = 32'hBFC00500;
    step(mk(32'hBFC00500, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0), e);
    e = idle_e("sys2_flush"); e.allow = 0; e.flush = 1; e.fpc = 32'hBFC00380;
    step(idle_r(), e);
    @(posedge clk); @(negedge clk); #2;
    reset = 1;
    #1 n_checks++;
    if (ws_flush !== 1'b0 || ws_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_flush flush=%b allowin=%b required flush=0 allowin=1", ws_flush, ws_allowin);
    end
    e = idle_e("in_reset"); e.cyc = cyc + 1; q.push_back(e);
    @(posedge clk); #1 reset = 0;
    e = idle_e("addu_after_reset"); e.we = 1; e.wa = 9; e.wd = 32'h1234;
    step(mk(32'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h1234), e);
    step(idle_r(), idle_e("final_idle"));
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
